// File: rtl/bs_adder_pkg.sv
// Shared ALU definitions for the bit-serial adder: FSM state encoding and op codes.
package bs_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fa_1bit.sv
// Combinational 1-bit full-adder cell; the only arithmetic element of the serial adder.
module fa_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bs_adder.sv
// Bit-serial LSB-first adder with start/busy/done handshake and sum/cout/ovf/zero flags.
// Optional subtract support (op port) is enabled by defining BS_ADDER_SUB_EN.
module bs_adder
    import bs_adder_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef BS_ADDER_SUB_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

`ifndef BS_ADDER_SUB_EN
    localparam logic op = OP_ADD;
`endif

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   s_sr;
    logic               c;
    logic [CNT_W-1:0]   cnt;
    logic               sub_sel;
    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   s_next;

    // Subtraction reuses the adder as a + ~b + ~cin = a - b - cin.
    assign sub_sel = (op == OP_SUB);
    assign s_next  = {fa_sum, s_sr[WIDTH-1:1]};

    fa_1bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // NOTE: all state here is updated with non-blocking assignments so every register
    // samples pre-edge values; blocking would let the shift chain ripple within one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub_sel ? ~b : b;
                        c     <= cin ^ sub_sel;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    s_sr <= s_next;
                    c    <= fa_cout;
                    cnt  <= cnt + 1'b1;
                    // Last bit: c is the carry into the MSB, so results and done land with DONE.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum   <= s_next;
                        cout  <= fa_cout;
                        ovf   <= fa_cout ^ c;
                        zero  <= (s_next == '0);
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bs_adder.sv
// Scoreboard bench for bs_adder (WIDTH=8): reference model queues expected results, a monitor checks them.
module tb_bs_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_val;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    always #5 clk = ~clk;

    bs_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef BS_ADDER_SUB_EN
        .op    (op_val),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf),
        .zero  (zero)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           due;
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   edge_cnt = 0;
    int   wait_cnt = 0;
    bit   armed    = 0;
    int   tests    = 0;
    int   fails    = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values, unsigned and signed.
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sub, int due);
        exp_t e;
        int ux = int'(x);
        int uy = int'(y);
        int sx = x[W-1] ? ux - (1 << W) : ux;
        int sy = y[W-1] ? uy - (1 << W) : uy;
        int ci_i = ci ? 1 : 0;
        int r_u;
        int r_s;
        if (sub) begin
            r_u    = ux - uy - ci_i;
            r_s    = sx - sy - ci_i;
            e.cout = (ux >= uy + ci_i);
        end else begin
            r_u    = ux + uy + ci_i;
            r_s    = sx + sy + ci_i;
            e.cout = (r_u >= (1 << W));
        end
        e.sum  = r_u[W-1:0];
        e.ovf  = (r_s > (1 << (W - 1)) - 1) || (r_s < -(1 << (W - 1)));
        e.zero = (e.sum == '0);
        e.due  = due;
        return e;
    endfunction

    // Handshake model: an accepted op keeps the block busy for W+1 cycles, then one idle cycle.
    always @(posedge clk) begin
        edge_cnt++;
        if (rst === 1'b1) begin
            q.delete();
            wait_cnt = 0;
            held     = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0, due: 0};
            armed    = 1;
        end else if (armed) begin
            if (start && wait_cnt == 0) begin
                q.push_back(model(a, b, cin, op_val, edge_cnt + W));
                wait_cnt = W + 1;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard on the falling edge.
    always @(negedge clk) begin
        if (armed) begin
            exp_t e;
            check("busy", busy, wait_cnt != 0);
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    e = q.pop_front();
                    check("done_edge", edge_cnt, e.due);
                    held = e;
                end
            end else if (q.size() > 0 && q[0].due == edge_cnt) begin
                check("done_missing", done, 1'b1);
                held = q.pop_front();
            end
            check("sum", sum, held.sum);
            check("cout", cout, held.cout);
            check("ovf", ovf, held.ovf);
            check("zero", zero, held.zero);
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic op_pulse(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sub);
        @(negedge clk);
        a      = x;
        b      = y;
        cin    = ci;
        op_val = sub;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        a      = W'($urandom);
        b      = W'($urandom);
        cin    = 1'($urandom);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        op_val = 1'b0;
        idle(3);
        rst = 1'b0;

        op_pulse(8'h7F, 8'h01, 1'b0, 1'b0);
        idle(W + 4);
        op_pulse(8'hFF, 8'h01, 1'b0, 1'b0);
        idle(W + 4);

        // A second start while busy must be ignored.
        op_pulse(8'h3C, 8'h42, 1'b1, 1'b0);
        idle(2);
        a = 8'h11;
        b = 8'h22;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(W + 4);

        // Start held high: back-to-back ops every W+2 cycles.
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        idle(30);
        start = 1'b0;
        idle(W + 4);

        // Reset mid-run aborts the op.
        op_pulse(8'hAA, 8'h55, 1'b0, 1'b0);
        idle(4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        op_pulse(8'h01, 8'h01, 1'b0, 1'b0);
        idle(W + 4);

`ifdef BS_ADDER_SUB_EN
        op_pulse(8'h05, 8'h07, 1'b0, 1'b1);
        idle(W + 4);
        op_pulse(8'h80, 8'h01, 1'b0, 1'b1);
        idle(W + 4);
`endif

        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
`ifdef BS_ADDER_SUB_EN
            op_val = 1'($urandom);
`endif
            start = 1'b1;
            idle($urandom_range(1, 3));
            start = 1'b0;
            if ($urandom_range(0, 11) == 0) begin
                idle($urandom_range(0, W));
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            idle($urandom_range(0, W + 3));
        end

        idle(W + 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
